// File: rtl/my_package.sv
// my_package: shared widths and types for the lane accumulator datapath.
//   my_width       default operand lane width
//   MY_LANES       default operands per beat
//   MY_ACC_EXTRA   default accumulator headroom bits above the lane sum
//   my_acc_state_t state of the accumulate/output stage
package my_package;

  localparam int my_width     = 8;
  localparam int MY_LANES     = 4;
  localparam int MY_ACC_EXTRA = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2
  } my_acc_state_t;

endpackage

// File: rtl/my_lane_accumulator_adder_tree.sv
// my_adder_tree: purely combinational unsigned sum of LANES operands.
//   i_data  LANES*WIDTH  packed operands, lane i = i_data[i*WIDTH +: WIDTH]
//   o_sum   SUM_W        exact sum, wide enough that it never truncates
module my_adder_tree #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int SUM_W = WIDTH + $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [SUM_W-1:0]       o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_sum = o_sum + SUM_W'(i_data[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/my_lane_accumulator.sv
// my_lane_accumulator: sums LANES unsigned operands per beat, then emits one
// sum per beat (mode 0) or a saturating sum across a packet delimited by
// in_last (mode 1). Valid/ready on both sides.
//   clock, reset      clock; synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_data           LANES*WIDTH packed unsigned operands
//   in_last           last beat of a mode-1 packet
//   in_mode           0 = per-beat sum, 1 = packet accumulate (sampled on first beat)
//   out_valid/out_ready output handshake
//   out_data          OUT_W-bit result
//   out_overflow      result was saturated
module my_lane_accumulator
  import my_package::*;
#(
  parameter int WIDTH     = my_width,
  parameter int LANES     = MY_LANES,
  parameter int ACC_EXTRA = MY_ACC_EXTRA
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_data,
  input  logic                         in_last,
  input  logic                         in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+$clog2(LANES)+ACC_EXTRA-1:0] out_data,
  output logic                         out_overflow
);

  localparam int SUM_W = WIDTH + $clog2(LANES);
  localparam int OUT_W = SUM_W + ACC_EXTRA;

  // Returns {overflow, value}; value clamps to all-ones when the true sum
  // does not fit in OUT_W bits.
  function automatic logic [OUT_W:0] sat_add(input logic [OUT_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [OUT_W:0] total;
    total = {1'b0, a} + (OUT_W+1)'(b);
    if (total[OUT_W]) begin
      return {1'b1, {OUT_W{1'b1}}};
    end
    return total;
  endfunction

  logic [SUM_W-1:0] w_sum_p0;
  logic             w_beat_mode;
  logic             w_beat_last;
  logic             w_in_fire;
  logic             w_s1_accept;
  logic             w_s2_take;
  logic [OUT_W:0]   w_sat_p1;
  logic [OUT_W-1:0] w_sum_ext_p1;

  logic             r_first;
  logic             r_pkt_mode;
  logic             r_vld_p1;
  logic [SUM_W-1:0] r_sum_p1;
  logic             r_last_p1;
  logic             r_mode_p1;

  my_acc_state_t    r_state_p2;
  logic [OUT_W-1:0] r_acc_p2;
  logic             r_ovf_p2;

  // ---- Stage 0: lane adder in front of the S1 register ----
  my_adder_tree #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_adder_tree (
    .i_data (in_data),
    .o_sum  (w_sum_p0)
  );

  // Mode is latched on the first beat of a packet and held for the rest.
  // Mode-0 beats are always their own packet, so they count as "last".
  assign w_beat_mode = r_first ? in_mode : r_pkt_mode;
  assign w_beat_last = !w_beat_mode || in_last;

  assign w_s2_take   = (r_state_p2 != ST_FULL) || out_ready;
  assign w_s1_accept = !r_vld_p1 || w_s2_take;
  assign w_in_fire   = in_valid && w_s1_accept;
  assign in_ready    = w_s1_accept;

  // ---- Stage 1: registered lane sum, last and mode ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_first    <= 1'b1;
      r_pkt_mode <= 1'b0;
    end else begin
      if (w_s1_accept) begin
        r_vld_p1 <= in_valid;
      end
      if (w_in_fire) begin
        r_first <= w_beat_last;
        if (r_first) begin
          r_pkt_mode <= in_mode;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_in_fire) begin
      r_sum_p1  <= w_sum_p0;
      r_last_p1 <= w_beat_last;
      r_mode_p1 <= w_beat_mode;
    end
  end

  assign w_sum_ext_p1 = OUT_W'(r_sum_p1);
  assign w_sat_p1     = sat_add(r_acc_p2, r_sum_p1);

  // ---- Stage 2: accumulate / hold result until consumed ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_p2 <= ST_EMPTY;
      r_acc_p2   <= '0;
      r_ovf_p2   <= 1'b0;
    end else begin
      case (r_state_p2)
        ST_EMPTY: begin
          if (r_vld_p1) begin
            r_acc_p2   <= w_sum_ext_p1;
            r_ovf_p2   <= 1'b0;
            r_state_p2 <= (!r_mode_p1 || r_last_p1) ? ST_FULL : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_vld_p1) begin
            r_acc_p2   <= w_sat_p1[OUT_W-1:0];
            r_ovf_p2   <= r_ovf_p2 | w_sat_p1[OUT_W];
            r_state_p2 <= r_last_p1 ? ST_FULL : ST_ACCUM;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            // Consume and, if S1 holds a beat, start the next packet now.
            r_ovf_p2 <= 1'b0;
            if (r_vld_p1) begin
              r_acc_p2   <= w_sum_ext_p1;
              r_state_p2 <= (!r_mode_p1 || r_last_p1) ? ST_FULL : ST_ACCUM;
            end else begin
              r_state_p2 <= ST_EMPTY;
            end
          end
        end
        default: begin
          r_state_p2 <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid    = (r_state_p2 == ST_FULL);
  assign out_data     = r_acc_p2;
  assign out_overflow = r_ovf_p2;

endmodule

// File: tb/tb_my_lane_accumulator.sv
module tb_my_lane_accumulator;

  localparam int WIDTH     = 8;
  localparam int LANES     = 4;
  localparam int ACC_EXTRA = 4;
  localparam int OUT_W     = 14;
  localparam longint MAXV  = 16383;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_overflow;

  my_lane_accumulator #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .ACC_EXTRA (ACC_EXTRA)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint data;
    bit     ovf;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: packet-level arithmetic on unbounded integers.
  bit     m_first = 1'b1;
  bit     m_mode  = 1'b0;
  longint m_total = 0;

  bit rdy_random = 1'b0;
  bit rdy_force  = 1'b1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint lane_sum(input logic [31:0] d);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += longint'(d[i*8 +: 8]);
    return s;
  endfunction

  task automatic model_accept(input logic [31:0] d, input bit last, input bit mode);
    exp_t e;
    if (m_first) m_mode = mode;
    if (!m_mode) begin
      e.data = lane_sum(d);
      e.ovf  = 1'b0;
      exp_q.push_back(e);
      m_first = 1'b1;
    end else begin
      m_total += lane_sum(d);
      if (last) begin
        e.data = (m_total > MAXV) ? MAXV : m_total;
        e.ovf  = (m_total > MAXV);
        exp_q.push_back(e);
        m_total = 0;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(negedge clock);
      #1;
      out_ready = rdy_random ? 1'($urandom) : rdy_force;
    end
  end

  // Monitor / scoreboard checker
  bit               hold_valid = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic             hold_ovf;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (reset) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hold_data);
          check("hold_ovf", out_overflow, hold_ovf);
        end
        hold_valid = out_valid && !out_ready;
        hold_data  = out_data;
        hold_ovf   = out_overflow;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_overflow", out_overflow, e.ovf);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit last, input bit mode,
                      input int budget, output bit ok);
    @(negedge clock);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = mode;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #3;
      if (in_ready) begin
        model_accept(d, last, mode);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    if (ok) #2;
    in_valid = 1'b0;
  endtask

  task automatic sendc(input string name, input logic [31:0] d, input bit last,
                       input bit mode);
    bit ok;
    send(d, last, mode, 40, ok);
    check(name, ok, 1);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clock);
    repeat (3) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_first = 1'b1;
    m_total = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    bit ok;
    logic [31:0] d;
    rdy_force = 1'b1;
    repeat (3) @(negedge clock);
    do_reset();

    // Mode 0 {1,2,3,4}: 10, two samples after accept
    sendc("acc_1234", 32'h04030201, 1'b0, 1'b0);
    @(negedge clock); #4;
    check("lat_early_valid", out_valid, 0);
    @(negedge clock); #4;
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 10);
    drain("drain_1234");

    // Back-to-back 1020 then 1 in consecutive cycles
    sendc("acc_ff", 32'hFFFFFFFF, 1'b0, 1'b0);
    sendc("acc_0001", 32'h01000000, 1'b0, 1'b0);
    @(negedge clock); #4;
    check("b2b_valid0", out_valid, 1);
    check("b2b_data0", out_data, 1020);
    @(negedge clock); #4;
    check("b2b_valid1", out_valid, 1);
    check("b2b_data1", out_data, 1);
    drain("drain_b2b");

    // Mode 1, 3 beats -> 3060, then a mode-0 beat
    for (int i = 0; i < 3; i++) sendc("acc_m1", 32'hFFFFFFFF, (i == 2), 1'b1);
    sendc("acc_m0_after", 32'h01010101, 1'b0, 1'b0);
    drain("drain_m1");

    // Mode 1, 17 beats of 255 saturate; next packet clean
    for (int i = 0; i < 17; i++) sendc("acc_sat", 32'hFFFFFFFF, (i == 16), 1'b1);
    sendc("acc_after_sat", 32'h01010101, 1'b1, 1'b1);
    drain("drain_sat");

    // Backpressure: two beats absorbed, then in_ready low
    rdy_force = 1'b0;
    @(negedge clock);
    sendc("bp_b0", 32'h00000001, 1'b0, 1'b0);
    sendc("bp_b1", 32'h00000002, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    #4;
    check("bp_in_ready_low", in_ready, 0);
    send(32'h00000003, 1'b0, 1'b0, 4, ok);
    check("bp_b2_blocked", ok, 0);
    rdy_force = 1'b1;
    sendc("bp_b2", 32'h00000003, 1'b0, 1'b0);
    sendc("bp_b3", 32'h00000004, 1'b0, 1'b0);
    drain("drain_bp");

    // Reset mid-packet discards partial sum
    sendc("rp_b0", 32'h0A0A0A0A, 1'b0, 1'b1);
    sendc("rp_b1", 32'h0A0A0A0A, 1'b0, 1'b1);
    do_reset();
    sendc("rp_new", 32'h02020202, 1'b1, 1'b1);
    drain("drain_rp");

    // Randomized traffic with random backpressure
    rdy_random = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < LANES; i++)
        d[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      send(d, ($urandom_range(0, 9) == 0), 1'($urandom), 60, ok);
      check("rnd_accept", ok, 1);
      if ($urandom_range(0, 4) == 0) @(negedge clock);
    end
    rdy_random = 1'b0;
    rdy_force  = 1'b1;
    drain("drain_rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
